seven_seg_scanner: RTL
======================

// Module: seven_seg_scanner
// PURPOSE
//  Consumes the 32-bit display word routed out of the result-steering logic and drives the 8-digit
//  multiplexed 7-segment display (hex digits, active-low segments and anodes). Commits a newly loaded
//  value only at a frame boundary, so one scan never mixes old and new digits. Sits between the
//  result-steering logic and the board display pins.
// PARAMETERS
//  WIDTH     32       display word width; DIGITS = WIDTH/4 (WIDTH multiple of 4, 4..32)
//  PRESCALE  100000   clk cycles each digit is lit (>=2)
// PORTS
//  clk        in   1         system clock, all logic on rising edge
//  reset_n    in   1         synchronous, active-low reset
//  value_in   in   WIDTH     word to display, nibble k -> digit k (digit 0 rightmost)
//  load       in   1         1-cycle strobe: capture value_in as pending
//  blank_lz   in   1         1 = blank leading zero digits (digit 0 never blanked)
//  enable     in   1         0 = display dark, scan frozen
//  seg        out  7         segments {g,f,e,d,c,b,a}, active-low
//  dp         out  1         decimal point, active-low, constant 1 (off)
//  an         out  DIGITS    digit anodes, active-low, one-hot-low when lit
//  frame_done out  1         1-cycle pulse on every frame wrap (digit DIGITS-1 -> 0)
// BEHAVIOUR
//  Reset (reset_n=0 at edge): shown=0, pending=0, pend_v=0, presc=0, idx=0; seg=7'h7F, an='1, dp=1,
//   frame_done=0. Applies regardless of in-flight load.
//  Prescaler: presc counts 0..PRESCALE-1 while enable=1; tick = enable && presc==PRESCALE-1; presc
//   returns to 0 on tick. On tick, idx <= (idx==DIGITS-1) ? 0 : idx+1. wrap = tick && idx==DIGITS-1.
//  enable=0: presc and idx hold; next edge an='1, seg=7'h7F. Loads still accepted.
//  Load: load=1 -> pending<=value_in, pend_v<=1; later load before commit overwrites (latest wins).
//  Commit on wrap when pend_v: shown<=pending, pend_v<=0.
//  Load and wrap in same cycle: shown<=value_in directly, pend_v<=0 (the fresh value wins).
//  Outputs registered: at each edge an/seg are computed from idx and shown as they stood before it.
//   An idx or shown change is therefore visible on an/seg one cycle later.
//   Minimum load-to-display latency is 2 cycles: load in the wrap cycle, then 1 output cycle.
//  an: bit idx = 0, all other bits = 1.
//  seg = hex decode of shown[4*idx+:4]:
//   0=1000000  1=1111001  2=0100100  3=0110000  4=0011001  5=0010010  6=0000010  7=1111000
//   8=0000000  9=0010000  A=0001000  b=0000011  C=1000110  d=0100001  E=0000110  F=0001110
//  Leading-zero blank: if blank_lz, idx>0, and shown[WIDTH-1:4*idx]==0, then seg=7'h7F.
//   an still asserts, so scan timing is unchanged.
//  frame_done: registered, 1 in the cycle after wrap.
//  Widths: presc is $clog2(PRESCALE) bits, idx is $clog2(DIGITS) bits (min 1). No overflow past terminal.
// STRUCTURE
//  Package seg_pkg: SEG_BLANK=7'h7F, the 16-entry segment table, function hex2seg(logic [3:0]).
//  One sub-module, hex_to_7seg (combinational nibble->seg). Scanner holds the prescaler, idx, the
//   pending/shown registers and the output registers.
// TESTING (WIDTH=32, PRESCALE=4)
//  1 reset_n=0 for 2 cycles -> an=8'hFF, seg=7'h7F, dp=1, frame_done=0; after release and enable=1,
//    an=8'hFE and seg=7'h40 (digit 0 shows "0").
//  2 load 32'h1234_5678, run 2 frames -> after commit, an steps FE,FD,..,7F every 4 cycles, seg 8,7,..,1
//    (8=7'h00, 1=7'h79); frame_done pulses every 32 cycles.
//  3 shown=32'h0000_00A0, blank_lz=1 -> digit0 seg=7'h40, digit1 seg=7'h08, digits2-7 seg=7'h7F;
//    blank_lz=0 -> digits2-7 seg=7'h40.
//  4 load 32'hFFFF_FFFF mid-frame (idx=3), then load 32'h2222_2222 before wrap -> digits 4-7 of that
//    frame still show the old value; the next frame shows all "2" (7'h24); FFFF_FFFF is never shown.
//  5 load in the exact wrap cycle -> value shown from digit 0 of the new frame; pend_v=0 afterwards.
//  6 enable=0 for 10 cycles mid-digit -> an=FF, idx/presc frozen, resumes the same digit with the
//    remaining count. reset_n=0 mid-frame -> all state cleared next edge.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared segment constants and the hex-to-segment lookup for the display scanner.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry k holds the pattern for hex digit k (packed MSB-first, so F is listed first)
  localparam logic [15:0][6:0] SEG_TAB = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    return SEG_TAB[h];
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low 7-segment pattern.
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex2seg(hex_i);

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed 8-digit hex display driver. A newly loaded word is held pending and
// only committed at a frame wrap, so a single scan never mixes old and new digits.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 100000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   value_in,
  input  logic               load,
  input  logic               blank_lz,
  input  logic               enable,
  output logic [6:0]         seg,
  output logic               dp,
  output logic [WIDTH/4-1:0] an,
  output logic               frame_done
);

  localparam int DIGITS = WIDTH / 4;
  localparam int IDXW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW     = $clog2(PRESCALE);

  logic [PW-1:0]     presc_q, presc_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  shown_q, shown_d;
  logic [WIDTH-1:0]  pending_q, pending_d;
  logic              pend_v_q, pend_v_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              fd_q;

  logic              tick, last_dig, wrap;
  logic [3:0]        nib;
  logic [6:0]        dec_seg;
  logic              lz_blank;

  assign tick     = enable && (presc_q == PW'(PRESCALE - 1));
  assign last_dig = (idx_q == IDXW'(DIGITS - 1));
  assign wrap     = tick && last_dig;

  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (enable) presc_d = tick ? '0 : presc_q + 1'b1;
    if (tick)   idx_d   = last_dig ? '0 : idx_q + 1'b1;
  end

  // A load coinciding with the wrap bypasses pending so the fresh value wins
  always_comb begin
    shown_d   = shown_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    if (load && wrap) begin
      shown_d   = value_in;
      pending_d = value_in;
      pend_v_d  = 1'b0;
    end else if (load) begin
      pending_d = value_in;
      pend_v_d  = 1'b1;
    end else if (wrap && pend_v_q) begin
      shown_d  = pending_q;
      pend_v_d = 1'b0;
    end
  end

  assign nib      = shown_q[{idx_q, 2'b00} +: 4];
  assign lz_blank = blank_lz && (idx_q != '0) && ((shown_q >> {idx_q, 2'b00}) == '0);

  hex_to_7seg u_dec (
    .hex_i (nib),
    .seg_o (dec_seg)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    if (enable) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = lz_blank ? SEG_BLANK : dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      shown_q   <= '0;
      pending_q <= '0;
      pend_v_q  <= 1'b0;
      seg_q     <= SEG_BLANK;
      an_q      <= '1;
      fd_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      shown_q   <= shown_d;
      pending_q <= pending_d;
      pend_v_q  <= pend_v_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      fd_q      <= wrap;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign dp         = 1'b1;
  assign frame_done = fd_q;

endmodule
